aes256_stream_ctrl: RTL

Controller that sequences the AES-256 loading core: it accepts a 256-bit master key, runs key expansion, then accepts 128-bit plaintext blocks one at a time. For each block it issues the encryption request and forwards the 16 serialized ciphertext bytes downstream. It sits between the system-side block source and the core's key/data/byte-stream ports, and owns all core handshakes, block counting and hang detection.

---
 rtl/aes256_ctrl_pkg.sv | 19 +
 rtl/aes256_ctrl_watchdog.sv | 38 +++
 rtl/aes256_stream_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/aes256_ctrl_pkg.sv
// Shared types and sizes for the AES-256 stream controller.
package aes256_ctrl_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_KEY_W       = 256;
    localparam int AES_BLK_W       = 128;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_START = 3'd1,
        KEY_WAIT  = 3'd2,
        READY     = 3'd3,
        ENC_REQ   = 3'd4,
        ENC_WAIT  = 3'd5,
        STREAM    = 3'd6,
        ERR       = 3'd7
    } state_t;

endpackage

// File: rtl/aes256_ctrl_watchdog.sv
// Response watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES.
module aes256_ctrl_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;

    // Expiry depends only on registered state so the FSM can use it freely.
    assign expired = enable && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes256_stream_ctrl.sv
// Sequences the AES-256 core: key load and expansion, per-block encryption
// request, byte forwarding, block counting and hang/protocol error flags.
module aes256_stream_ctrl
    import aes256_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_key_valid,
    input  logic [255:0]         cfg_key,
    output logic                 cfg_key_ready,
    input  logic                 blk_valid,
    input  logic [127:0]         blk_data,
    output logic                 blk_ready,
    output logic                 out_valid,
    output logic [7:0]           out_byte,
    output logic                 out_last,
    output logic                 core_key_expand_start,
    output logic [255:0]         core_master_key,
    input  logic                 core_key_ready,
    output logic                 core_next_val_req,
    output logic [127:0]         core_data_in,
    input  logic                 core_enc_done,
    input  logic                 core_next_val_ready,
    input  logic [7:0]           core_data_out,
    output logic                 busy,
    output logic [CNT_W-1:0]     blk_count,
    output logic                 err_timeout,
    output logic                 err_protocol
);

    localparam logic [3:0] LAST_BYTE = 4'(AES_BLOCK_BYTES - 1);

    state_t                 state_q, state_d;
    logic [AES_KEY_W-1:0]   key_q, key_d;
    logic [AES_BLK_W-1:0]   blk_q, blk_d;
    logic [3:0]             byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]       blk_count_q, blk_count_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_byte_q, out_byte_d;
    logic                   out_last_q, out_last_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   err_protocol_q, err_protocol_d;
    logic                   key_rdy_prev_q, key_rdy_prev_d;

    logic key_hs, blk_hs, key_rise, byte_take;
    logic wd_clear, wd_enable, wd_expired;

    assign cfg_key_ready = (state_q == IDLE) || (state_q == READY);
    assign blk_ready     = (state_q == READY) && !cfg_key_valid;
    assign key_hs        = cfg_key_valid && cfg_key_ready;
    assign blk_hs        = blk_valid && blk_ready;
    assign key_rise      = core_key_ready && !key_rdy_prev_q;
    assign wd_enable     = (state_q == KEY_WAIT) || (state_q == ENC_WAIT) || (state_q == STREAM);

    aes256_ctrl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        blk_d          = blk_q;
        byte_cnt_d     = byte_cnt_q;
        blk_count_d    = blk_count_q;
        out_valid_d    = 1'b0;
        out_byte_d     = out_byte_q;
        out_last_d     = 1'b0;
        err_timeout_d  = err_timeout_q;
        err_protocol_d = err_protocol_q;
        key_rdy_prev_d = core_key_ready;
        byte_take      = 1'b0;

        case (state_q)
            IDLE: if (key_hs) begin
                key_d   = cfg_key;
                state_d = KEY_START;
            end
            KEY_START: state_d = KEY_WAIT;
            KEY_WAIT: begin
                if (key_rise) begin
                    state_d = READY;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ERR;
                end
            end
            READY: begin
                if (key_hs) begin
                    key_d   = cfg_key;
                    state_d = KEY_START;
                end else if (blk_hs) begin
                    blk_d   = blk_data;
                    state_d = ENC_REQ;
                end
            end
            ENC_REQ: state_d = ENC_WAIT;
            ENC_WAIT: begin
                if (core_enc_done) begin
                    byte_cnt_d = '0;
                    state_d    = STREAM;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ERR;
                end
            end
            STREAM: begin
                // The last byte is on the output this cycle; READY follows it.
                if (out_last_q) begin
                    state_d = READY;
                end else if (core_next_val_ready) begin
                    byte_take   = 1'b1;
                    out_valid_d = 1'b1;
                    out_byte_d  = core_data_out;
                    byte_cnt_d  = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        out_last_d  = 1'b1;
                        blk_count_d = blk_count_q + 1'b1;
                    end
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ERR;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase

        if (core_next_val_ready && (state_q != STREAM)) begin
            err_protocol_d = 1'b1;
        end

        wd_clear = (state_d != state_q) || byte_take;
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block; the
    // key/data registers are reset as well because they drive visible ports.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            key_q          <= '0;
            blk_q          <= '0;
            byte_cnt_q     <= '0;
            blk_count_q    <= '0;
            out_valid_q    <= 1'b0;
            out_byte_q     <= '0;
            out_last_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_protocol_q <= 1'b0;
            key_rdy_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            blk_q          <= blk_d;
            byte_cnt_q     <= byte_cnt_d;
            blk_count_q    <= blk_count_d;
            out_valid_q    <= out_valid_d;
            out_byte_q     <= out_byte_d;
            out_last_q     <= out_last_d;
            err_timeout_q  <= err_timeout_d;
            err_protocol_q <= err_protocol_d;
            key_rdy_prev_q <= key_rdy_prev_d;
        end
    end

    assign core_key_expand_start = (state_q == KEY_START);
    assign core_next_val_req     = (state_q == ENC_REQ);
    assign core_master_key       = key_q;
    assign core_data_in          = blk_q;
    assign busy                  = !((state_q == IDLE) || (state_q == READY) || (state_q == ERR));
    assign out_valid             = out_valid_q;
    assign out_byte              = out_byte_q;
    assign out_last              = out_last_q;
    assign blk_count             = blk_count_q;
    assign err_timeout           = err_timeout_q;
    assign err_protocol          = err_protocol_q;

endmodule
